// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared AES-128 decryption constants, state encoding and FIPS-197 vectors
package aes_dec_pkg;

  localparam int NR     = 10;
  localparam int KIDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

  localparam logic [127:0] FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// rtl/aes_dec_round_ctrl_if.sv - block handshakes, key-store index and round-datapath signals
interface aes_dec_round_ctrl_if #(
  parameter int KIDX_W = aes_dec_pkg::KIDX_W
);

  logic              in_valid;
  logic              in_ready;
  logic [127:0]      datain;
  logic [KIDX_W-1:0] key_idx;
  logic [127:0]      round_key;
  logic [127:0]      rnd_in;
  logic              rnd_last;
  logic [127:0]      rnd_out;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      dataout;
  logic              busy;

  // slave is the controller, master is the surrounding key store, datapath and stream ends
  modport slave (
    input  in_valid, datain, round_key, rnd_out, out_ready,
    output in_ready, key_idx, rnd_in, rnd_last, out_valid, dataout, busy
  );

  modport master (
    output in_valid, datain, round_key, rnd_out, out_ready,
    input  in_ready, key_idx, rnd_in, rnd_last, out_valid, dataout, busy
  );

endinterface

// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - iterative AES-128 decryption sequencer driving a shared inverse-round datapath
module aes_dec_round_ctrl #(
  parameter int NR     = aes_dec_pkg::NR,
  parameter int KIDX_W = aes_dec_pkg::KIDX_W
) (
  input  logic                clk,
  input  logic                rst,
  aes_dec_round_ctrl_if.slave bus
);

  import aes_dec_pkg::ctrl_state_e;
  import aes_dec_pkg::ST_IDLE;
  import aes_dec_pkg::ST_ROUND;
  import aes_dec_pkg::ST_DONE;

  localparam logic [KIDX_W-1:0] LAST_KEY  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] FIRST_CNT = KIDX_W'(NR - 1);

  ctrl_state_e       st_q, st_d;
  logic [127:0]      state_q, state_d;
  logic [KIDX_W-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      rcnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (st_q)
      ST_IDLE: begin
        // initial AddRoundKey uses the last expanded key, selected by key_idx=NR in IDLE
        if (bus.in_valid) begin
          state_d = bus.datain ^ bus.round_key;
          rcnt_d  = FIRST_CNT;
          st_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = bus.rnd_out;
        if (rcnt_q == '0) begin
          st_d = ST_DONE;
        end else begin
          rcnt_d = rcnt_q - KIDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.key_idx  = LAST_KEY;
    bus.rnd_last = 1'b0;
    case (st_q)
      ST_ROUND: begin
        bus.key_idx  = rcnt_q;
        bus.rnd_last = (rcnt_q == '0);
      end
      ST_DONE:  bus.key_idx = '0;
      default:  bus.key_idx = LAST_KEY;
    endcase
  end

  assign bus.in_ready  = (st_q == ST_IDLE);
  assign bus.out_valid = (st_q == ST_DONE);
  assign bus.busy      = (st_q == ST_ROUND) || (st_q == ST_DONE);
  assign bus.rnd_in    = state_q;
  assign bus.dataout   = (st_q == ST_DONE) ? state_q : '0;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb/tb_aes_dec_round_ctrl.sv - self-checking bench for aes_dec_round_ctrl with behavioural key store and inverse round
module tb_aes_dec_round_ctrl;
  import aes_dec_pkg::*;

  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_dec_round_ctrl_if #(.KIDX_W(KIDX_W)) bus ();

  aes_dec_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [16];
  logic [127:0] m_st  [NR+1];
  logic [127:0] pt2;
  bit           m_busy = 1'b0;
  int           m_cyc  = 0;
  bit           chk_en = 1'b0;
  int           cyc_n  = 0;
  int           ov_cnt = 0;
  bit           ov_prev = 1'b0;
  int           ov_rise [$];
  int           e_k;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   a [16];
    logic [7:0]   m [4];
    logic [7:0]   v;
    logic [127:0] r;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        a[c*4+w] = isbox[s[127-8*(((c-w+4)%4)*4+w) -: 8]] ^ k[127-8*(c*4+w) -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        if (last) v = a[c*4+w];
        else begin
          v = '0;
          for (int j = 0; j < 4; j++) v = v ^ gmul(a[c*4+j], m[(j-w+4)%4]);
        end
        r[127-8*(c*4+w) -: 8] = v;
      end
    return r;
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int k = NR - 1; k >= 0; k--) s = inv_round(s, rk[k], k == 0);
    return s;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = b;
      isbox[b] = x[7:0];
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int e);
    e = 0;
    while (bus.out_valid !== 1'b1 && e < 40) begin
      step();
      e++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_busy"},      bus.busy,      1'b0);
    chk({tag, "_key_idx"},   bus.key_idx,   NR);
    chk({tag, "_dataout"},   bus.dataout,   '0);
    chk({tag, "_rnd_in"},    bus.rnd_in,    '0);
    chk({tag, "_rnd_last"},  bus.rnd_last,  1'b0);
  endtask

  always_comb bus.round_key = rk[bus.key_idx];
  always_comb bus.rnd_out   = inv_round(bus.rnd_in, bus.round_key, bus.rnd_last);

  always @(posedge clk) cyc_n++;

  // model: a block is "in flight" for NR edges after acceptance, then waits for the consumer
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_cyc  = 0;
    end else if (!m_busy) begin
      if (bus.in_valid === 1'b1) begin
        m_busy  = 1'b1;
        m_cyc   = 1;
        m_st[0] = bus.datain ^ rk[NR];
        for (int k = 1; k <= NR; k++) m_st[k] = inv_round(m_st[k-1], rk[NR-k], k == NR);
      end
    end else if (m_cyc <= NR) begin
      m_cyc++;
    end else if (bus.out_ready === 1'b1) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!m_busy) e_k = NR;
      else if (m_cyc <= NR) e_k = NR - m_cyc;
      else e_k = 0;
      chk("cmp_in_ready",  bus.in_ready,  !m_busy);
      chk("cmp_busy",      bus.busy,      m_busy);
      chk("cmp_out_valid", bus.out_valid, m_busy && m_cyc > NR);
      chk("cmp_rnd_last",  bus.rnd_last,  m_busy && m_cyc == NR);
      chk("cmp_key_idx",   bus.key_idx,   e_k);
      chk("cmp_dataout",   bus.dataout,   (m_busy && m_cyc > NR) ? m_st[NR] : 128'h0);
      if (m_busy) chk("cmp_rnd_in", bus.rnd_in, m_st[(m_cyc > NR) ? NR : m_cyc - 1]);
      if (bus.out_valid === 1'b1 && !ov_prev) ov_rise.push_back(cyc_n);
      if (bus.out_valid === 1'b1) ov_cnt++;
      ov_prev = (bus.out_valid === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int base;
    int nrise;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.datain    = '0;
    build_tables();
    expand(FIPS_C1_KEY);

    chk("model_sbox00",  sbox[0],  8'h63);
    chk("model_isbox00", isbox[0], 8'h52);
    chk("model_rk10",    rk[NR],   128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_first",   FIPS_C1_CT ^ rk[NR], 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    chk("model_pt",      decrypt(FIPS_C1_CT), FIPS_C1_PT);
    pt2 = decrypt(CT2);

    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check_reset("rst0");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk_en = 1'b1;

    // FIPS-197 C.1 with backpressure
    step();
    bus.in_valid = 1'b1; bus.datain = FIPS_C1_CT;
    step();
    bus.in_valid = 1'b0; bus.datain = '0;
    chk("acc_rnd_in",  bus.rnd_in,  128'h7ad5fda789ef4e272bca100b3d9ff59f);
    chk("acc_key_idx", bus.key_idx, 4'd9);
    wait_ov(e);
    chk("fips_latency", e, 10);
    chk("fips_dataout", bus.dataout, 128'h00112233445566778899aabbccddeeff);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.datain   = CT2;
      step();
      chk("bp_dataout",   bus.dataout,   FIPS_C1_PT);
      chk("bp_in_ready",  bus.in_ready,  1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    base = ov_cnt;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_xfer_ov",   bus.out_valid, 1'b0);
    chk("bp_xfer_idle", bus.in_ready,  1'b1);
    repeat (3) step();
    chk("bp_one_xfer", ov_cnt - base, 1);
    chk("bp_no_accept", bus.busy, 1'b0);

    // back-to-back with in_valid held and out_ready tied high
    nrise = ov_rise.size();
    bus.in_valid = 1'b1; bus.datain = FIPS_C1_CT; bus.out_ready = 1'b1;
    wait_ov(e);
    chk("b2b_ov_a", bus.out_valid, 1'b1);
    chk("b2b_pt_a", bus.dataout, FIPS_C1_PT);
    bus.datain = CT2;
    step();
    wait_ov(e);
    chk("b2b_ov_b", bus.out_valid, 1'b1);
    chk("b2b_pt_b", bus.dataout, pt2);
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("b2b_rises", ov_rise.size() - nrise, 2);
    chk("b2b_spacing", (ov_rise.size() - nrise == 2) ? ov_rise[nrise+1] - ov_rise[nrise] : -1, 12);
    chk("b2b_idle", bus.in_ready, 1'b1);

    // early out_ready: no effect before DONE, one-cycle out_valid
    base = ov_cnt;
    bus.in_valid = 1'b1; bus.datain = CT2;
    step();
    bus.in_valid = 1'b0;
    repeat (14) step();
    chk("early_ov_cycles", ov_cnt - base, 1);
    chk("early_idle", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;

    // reset in the middle of a block
    bus.in_valid = 1'b1; bus.datain = FIPS_C1_CT;
    step();
    bus.in_valid = 1'b0;
    e = 0;
    while (bus.key_idx !== 4'd5 && e < 20) begin
      step();
      e++;
    end
    chk("mr_key5", bus.key_idx, 4'd5);
    base = ov_cnt;
    #2 rst = 1'b1;
    #1 check_reset("mr");
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (15) step();
    chk("mr_no_output", ov_cnt - base, 0);
    bus.in_valid = 1'b1; bus.datain = FIPS_C1_CT;
    step();
    bus.in_valid = 1'b0;
    wait_ov(e);
    chk("mr_latency", e, 10);
    chk("mr_dataout", bus.dataout, 128'h00112233445566778899aabbccddeeff);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    chk("mr_done_idle", bus.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
